mem_dma_engine: RTL and testbench
=================================

MEM_DMA_ENGINE -- requirements
Module: mem_dma_engine

Interface
REQ-001 Parameter AW, default 12, memory address width (4096 words).
REQ-002 Parameter DW, default 16, memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 mode  input  1  operation select: 0 = COPY, 1 = FILL.
REQ-007 src_addr  input  AW  COPY source base address.
REQ-008 dst_addr  input  AW  destination base address (COPY and FILL).
REQ-009 length  input  AW+1  word count, 0..4096.
REQ-010 fill_data  input  DW  FILL pattern word.
REQ-011 busy  output  1  high while the operation is in progress (RD/WR/FILL states).
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 checksum  output  DW  modulo-2^DW sum of all words written by the last operation.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_address  output  AW  memory address.
REQ-016 mem_write_data  output  DW  memory write data.
REQ-017 mem_read_data  input  DW  memory read data, combinational from mem_address.

Function
REQ-018 States SHALL be IDLE, RD, WR, FILL and DONE.
REQ-019 In IDLE, start=1 SHALL latch all operands, clear checksum, and go to RD (COPY) or FILL (FILL); start in any other state SHALL be ignored.
REQ-020 length=0 SHALL go from IDLE directly to DONE with no memory writes.
REQ-021 COPY direction SHALL be descending (last word first) when dst_addr > src_addr unsigned, otherwise ascending.
REQ-022 RD SHALL drive mem_address = current source address and mem_we=0, latch mem_read_data into a data register, then go to WR.
REQ-023 WR SHALL drive mem_address = current destination address, mem_we=1 and mem_write_data = the data register, add that word to checksum, then step both pointers and go to RD, or to DONE after the last word.
REQ-024 FILL SHALL write fill_data to one destination address per cycle with mem_we=1, add each word to checksum, and go to DONE after the last word.
REQ-025 Timing: with start sampled at edge k, busy SHALL be high in cycles k+1..k+2N for COPY (k+1..k+N for FILL).
REQ-026 done SHALL be high only in cycle k+2N+1 for COPY (k+N+1 for FILL), then the engine SHALL return to IDLE.
REQ-027 Address arithmetic SHALL wrap modulo 2^AW in both directions.
REQ-028 mem_we SHALL be 0 in IDLE, RD and DONE.
REQ-029 mem_address SHALL be 0 in IDLE.
REQ-030 checksum SHALL hold its value from DONE until the next accepted start.

Reset
REQ-031 rst=1 SHALL force IDLE, busy=0, done=0, mem_we=0, mem_address=0, mem_write_data=0 and checksum=0 on the next edge.
REQ-032 Reset SHALL apply mid-operation, aborting the operation with no further writes and no done pulse.

Structure
REQ-033 A shared package SHALL hold the state enumeration and the MODE_COPY and MODE_FILL constants.
REQ-034 The block SHALL be a single module with no sub-modules; it connects directly to memory_unit-style ports.

Verification
REQ-035 FILL dst=0x100, len=4, fill_data=0xA5A5 -> words 0x100..0x103 = 0xA5A5, done at k+5, checksum=0x9694.
REQ-036 COPY src=0x010, dst=0x200, len=3, source = 1,2,3 -> 0x200..0x202 = 1,2,3, done at k+7, checksum=0x0006.
REQ-037 COPY src=0x000, dst=0x001, len=4, source = 0x11,0x22,0x33,0x44 -> 0x001..0x004 = 0x11,0x22,0x33,0x44 (descending order, no smear).
REQ-038 FILL dst=0xFFE, len=4, fill_data=0x0001 -> writes 0xFFE, 0xFFF, 0x000, 0x001 (wrap); checksum=0x0004.
REQ-039 length=0 -> done at k+1, mem_we never asserted; a second start pulsed while busy -> ignored, single done pulse.
REQ-040 rst asserted at cycle k+3 of a len=8 FILL -> exactly 3 words written, IDLE next cycle, no done pulse, checksum=0.

Source files
------------

// File: rtl/mem_dma_engine_pkg.sv
// Shared types and constants for the memory DMA engine.
// Holds the FSM state encoding and the operation-mode select values.
package mem_dma_engine_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StWr,
      StFill,
      StDone
   } state_e;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma_engine.sv
// Word-wide memory copy/fill engine driving a single-port combinational-read memory.
// COPY alternates RD/WR per word; FILL writes one word per cycle; checksum sums written words.
module mem_dma_engine
   import mem_dma_engine_pkg::*;
#(
   parameter int unsigned AW = 12,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW:0]   length,
   input  logic [DW-1:0] fill_data,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] checksum,
   output logic          mem_we,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_write_data,
   input  logic [DW-1:0] mem_read_data
);

   localparam logic [AW:0]   CntOne  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] AddrOne = {{(AW-1){1'b0}}, 1'b1};

   state_e        state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          desc_q, desc_d;
   logic [DW-1:0] fill_q, fill_d;
   logic [DW-1:0] data_q, data_d;
   logic [DW-1:0] sum_q, sum_d;
   logic [AW-1:0] step;

   // All-ones is -1 modulo 2^AW, so both directions wrap naturally.
   assign step     = desc_q ? '1 : AddrOne;
   assign checksum = sum_q;

   always_comb begin
      state_d        = state_q;
      src_d          = src_q;
      dst_d          = dst_q;
      cnt_d          = cnt_q;
      desc_d         = desc_q;
      fill_d         = fill_q;
      data_d         = data_q;
      sum_d          = sum_q;
      busy           = 1'b0;
      done           = 1'b0;
      mem_we         = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               // Overlapping copy with dst above src must run last-word-first to avoid smear.
               desc_d = (mode == MODE_COPY) && (dst_addr > src_addr);
               src_d  = desc_d ? src_addr + length[AW-1:0] - AddrOne : src_addr;
               dst_d  = desc_d ? dst_addr + length[AW-1:0] - AddrOne : dst_addr;
               cnt_d  = length;
               fill_d = fill_data;
               sum_d  = '0;
               if (length == '0) begin
                  state_d = StDone;
               end else if (mode == MODE_FILL) begin
                  state_d = StFill;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            busy        = 1'b1;
            mem_address = src_q;
            data_d      = mem_read_data;
            state_d     = StWr;
         end
         StWr: begin
            busy           = 1'b1;
            mem_we         = 1'b1;
            mem_address    = dst_q;
            mem_write_data = data_q;
            sum_d          = sum_q + data_q;
            src_d          = src_q + step;
            dst_d          = dst_q + step;
            cnt_d          = cnt_q - CntOne;
            state_d        = (cnt_q == CntOne) ? StDone : StRd;
         end
         StFill: begin
            busy           = 1'b1;
            mem_we         = 1'b1;
            mem_address    = dst_q;
            mem_write_data = fill_q;
            sum_d          = sum_q + fill_q;
            dst_d          = dst_q + step;
            cnt_d          = cnt_q - CntOne;
            state_d        = (cnt_q == CntOne) ? StDone : StFill;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         desc_q  <= 1'b0;
         fill_q  <= '0;
         data_q  <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         desc_q  <= desc_d;
         fill_q  <= fill_d;
         data_q  <= data_d;
         sum_q   <= sum_d;
      end
   end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Scoreboard bench for mem_dma_engine: expected writes and done events are queued at issue
// time and popped by a negedge monitor whenever the engine writes or pulses done.
module tb_mem_dma_engine;

   localparam int AW = 12;
   localparam int DW = 16;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   typedef struct {
      int            cyc;
      logic [DW-1:0] sum;
   } done_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          mode;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;
   logic [AW:0]   length;
   logic [DW-1:0] fill_data;
   logic          busy;
   logic          done;
   logic [DW-1:0] checksum;
   logic          mem_we;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_write_data;
   logic [DW-1:0] mem_read_data;

   logic [DW-1:0] mem [4096];
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;

   wr_t   wr_q[$];
   done_t done_q[$];

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_dma_engine #(.AW(AW), .DW(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .mode          (mode),
      .src_addr      (src_addr),
      .dst_addr      (dst_addr),
      .length        (length),
      .fill_data     (fill_data),
      .busy          (busy),
      .done          (done),
      .checksum      (checksum),
      .mem_we        (mem_we),
      .mem_address   (mem_address),
      .mem_write_data(mem_write_data),
      .mem_read_data (mem_read_data)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we === 1'b1) mem[mem_address] <= mem_write_data;
      else if (ld_we) mem[ld_addr] <= ld_data;
   end

   assign mem_read_data = mem[mem_address];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write and every done pulse must match the head of its queue.
   wr_t   mon_w;
   done_t mon_d;
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (wr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=0x%0h:0x%0h required=none",
                     mem_address, mem_write_data);
         end else begin
            mon_w = wr_q.pop_front();
            check("wr_addr", 32'(mem_address), 32'(mon_w.a));
            check("wr_data", 32'(mem_write_data), 32'(mon_w.d));
         end
      end
      if (done === 1'b1) begin
         if (done_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=cycle%0d required=none", cyc);
         end else begin
            mon_d = done_q.pop_front();
            check("done_cycle", 32'(cyc), 32'(mon_d.cyc));
            check("done_checksum", 32'(checksum), 32'(mon_d.sum));
         end
      end
   end

   task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      wr_q.push_back(w);
   endtask

   task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(negedge clk);
      ld_we   = 1'b0;
   endtask

   // Issues one operation, expects done at k+lat with the given checksum, and counts busy cycles.
   task automatic run_op(input string name, input logic m, input logic [AW-1:0] s,
                         input logic [AW-1:0] d, input logic [AW:0] len,
                         input logic [DW-1:0] fd, input int lat, input logic [DW-1:0] sum,
                         input logic pulse_again);
      done_t e;
      int    k;
      int    bcnt;
      bit    seen;
      @(negedge clk);
      mode      = m;
      src_addr  = s;
      dst_addr  = d;
      length    = len;
      fill_data = fd;
      start     = 1'b1;
      k         = cyc;
      e.cyc     = k + lat;
      e.sum     = sum;
      done_q.push_back(e);
      bcnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (pulse_again && i == 0) begin
            start     = 1'b1;
            mode      = 1'b1;
            dst_addr  = 12'h500;
            length    = 13'd3;
            fill_data = 16'hBEEF;
         end
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (busy === 1'b1) bcnt++;
      end
      start = 1'b0;
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      check({name, "_busy_cycles"}, 32'(bcnt), 32'(lat - 1));
      repeat (2) @(negedge clk);
      check({name, "_checksum_hold"}, 32'(checksum), 32'(sum));
      check({name, "_queue_drained"}, 32'(wr_q.size()), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      mode      = 1'b0;
      src_addr  = '0;
      dst_addr  = '0;
      length    = '0;
      fill_data = '0;
      ld_we     = 1'b0;
      ld_addr   = '0;
      ld_data   = '0;

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_address), 32'd0);
      check("rst_wdata", 32'(mem_write_data), 32'd0);
      check("rst_checksum", 32'(checksum), 32'd0);
      rst = 1'b0;

      // FILL dst=0x100 len=4 0xA5A5
      for (int i = 0; i < 4; i++) push_wr(12'h100 + 12'(i), 16'hA5A5);
      run_op("fill4", 1'b1, 12'h000, 12'h100, 13'd4, 16'hA5A5, 5, 16'h9694, 1'b0);
      for (int i = 0; i < 4; i++) check("fill4_mem", 32'(mem[12'h100 + 12'(i)]), 32'hA5A5);

      // COPY src=0x010 dst=0x200 len=3; dst above src, so last word first
      load_word(12'h010, 16'd1);
      load_word(12'h011, 16'd2);
      load_word(12'h012, 16'd3);
      push_wr(12'h202, 16'd3);
      push_wr(12'h201, 16'd2);
      push_wr(12'h200, 16'd1);
      run_op("copy3", 1'b0, 12'h010, 12'h200, 13'd3, 16'h0000, 7, 16'h0006, 1'b0);
      for (int i = 0; i < 3; i++) check("copy3_mem", 32'(mem[12'h200 + 12'(i)]), 32'(i + 1));

      // Overlapping COPY src=0 dst=1 len=4
      load_word(12'h000, 16'h0011);
      load_word(12'h001, 16'h0022);
      load_word(12'h002, 16'h0033);
      load_word(12'h003, 16'h0044);
      push_wr(12'h004, 16'h0044);
      push_wr(12'h003, 16'h0033);
      push_wr(12'h002, 16'h0022);
      push_wr(12'h001, 16'h0011);
      run_op("overlap", 1'b0, 12'h000, 12'h001, 13'd4, 16'h0000, 9, 16'h00AA, 1'b0);
      for (int i = 0; i < 4; i++)
         check("overlap_mem", 32'(mem[12'h001 + 12'(i)]), 32'(16'h0011 * (i + 1)));

      // FILL wrapping past the top of memory
      push_wr(12'hFFE, 16'h0001);
      push_wr(12'hFFF, 16'h0001);
      push_wr(12'h000, 16'h0001);
      push_wr(12'h001, 16'h0001);
      run_op("wrap", 1'b1, 12'h000, 12'hFFE, 13'd4, 16'h0001, 5, 16'h0004, 1'b0);

      // Zero length: done at k+1, no writes
      run_op("len0", 1'b0, 12'h010, 12'h300, 13'd0, 16'h0000, 1, 16'h0000, 1'b0);

      // Ascending COPY with a second start pulsed while busy (ignored)
      push_wr(12'h008, 16'd1);
      push_wr(12'h009, 16'd2);
      run_op("restart", 1'b0, 12'h010, 12'h008, 13'd2, 16'h0000, 5, 16'h0003, 1'b1);

      // Reset during cycle k+3 of an 8-word FILL: three writes, no done
      for (int i = 0; i < 3; i++) push_wr(12'h300 + 12'(i), 16'h5A5A);
      @(negedge clk);
      mode      = 1'b1;
      dst_addr  = 12'h300;
      length    = 13'd8;
      fill_data = 16'h5A5A;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_we", 32'(mem_we), 32'd0);
      check("abort_addr", 32'(mem_address), 32'd0);
      check("abort_checksum", 32'(checksum), 32'd0);
      repeat (12) @(negedge clk);
      check("abort_writes_left", 32'(wr_q.size()), 32'd0);
      check("abort_done_left", 32'(done_q.size()), 32'd0);
      for (int i = 0; i < 3; i++) check("abort_mem", 32'(mem[12'h300 + 12'(i)]), 32'h5A5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
